// File: rtl/sd_param.sv
// sd_param: parametrised serial sequence detector.
//
// Samples one serial bit per enabled clock and compares the last N accepted
// bits against PATTERN (MSB = first bit received). A match pulses y for one
// cycle. Matches may overlap (OVERLAP=1) or may not share bits (OVERLAP=0).
//
// Build option: define SD_MATCH_CNT_EN to build the saturating match counter.
// Without it match_cnt is tied to zero and no counter logic exists; the port
// list is the same in both builds.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   x         in   serial data bit
//   en        in   sample enable; x is consumed only when en=1
//   clr       in   synchronous clear of history, y and counter (wins over en)
//   y         out  registered one-cycle detect pulse
//   match_cnt out  saturating count of detections (CNT_W bits)
module sd_param #(
  parameter int unsigned     N       = 4,
  parameter logic [N-1:0]    PATTERN = {{(N-1){1'b0}}, 1'b1},
  parameter int unsigned     OVERLAP = 1,
  parameter int unsigned     CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             en,
  input  logic             clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned  FW       = $clog2(N);
  localparam logic [FW-1:0] FILL_MAX = FW'(N - 1);

  logic [N-2:0]  r_hist;
  logic [N-2:0]  w_hist_d;
  logic [FW-1:0] r_fill;
  logic [FW-1:0] w_fill_d;
  logic          r_y;
  logic          w_y_d;
  logic [N-1:0]  w_window;
  logic          w_match;

  // Newest bit lands in the LSB so the window reads oldest-first from the MSB.
  assign w_window = {r_hist, x};

  // fill guards against history bits that were zero-filled by reset or clear.
  assign w_match = en && (r_fill == FILL_MAX) && (w_window == PATTERN);

  always_comb begin
    w_hist_d = r_hist;
    w_fill_d = r_fill;
    w_y_d    = 1'b0;
    if (clr) begin
      w_hist_d = '0;
      w_fill_d = '0;
    end else if (en) begin
      w_hist_d = w_window[N-2:0];
      if (w_match) begin
        w_y_d = 1'b1;
        // Non-overlapping: restart validity so no bit serves two matches.
        w_fill_d = (OVERLAP != 0) ? FILL_MAX : '0;
      end else if (r_fill != FILL_MAX) begin
        w_fill_d = r_fill + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
      r_fill <= '0;
      r_y    <= 1'b0;
    end else begin
      r_hist <= w_hist_d;
      r_fill <= w_fill_d;
      r_y    <= w_y_d;
    end
  end

  assign y = r_y;

`ifdef SD_MATCH_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;

  always_comb begin
    w_cnt_d = r_cnt;
    if (clr) begin
      w_cnt_d = '0;
    end else if (w_match && (r_cnt != CNT_MAX)) begin
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign match_cnt = r_cnt;
`else
  assign match_cnt = '0;
`endif

endmodule
